// File: rtl/data_assembly_register.sv
// WIDTH-bit operand register fed one byte at a time: single-shot loads/shifts plus a
// counted little-endian assembly mode. Define DR_PARITY_EN to add the per-lane Parity output.
module data_assembly_register #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH/8 + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [7:0]       I,
  input  logic [2:0]       FunSel,
  input  logic             E,
  input  logic [CW-1:0]    Len,
  input  logic             Sext,
  output logic [WIDTH-1:0] DROut,
  output logic [CW-1:0]    Count,
  output logic             Busy,
  output logic             Done,
  output logic             Err
`ifdef DR_PARITY_EN
  ,
  output logic [WIDTH/8-1:0] Parity
`endif
);

  localparam int unsigned NBYTES = WIDTH / 8;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'b000,
    OP_SLOAD  = 3'b001,
    OP_ZLOAD  = 3'b010,
    OP_SHL    = 3'b011,
    OP_SHR    = 3'b100,
    OP_START  = 3'b101,
    OP_APPEND = 3'b110,
    OP_CLEAR  = 3'b111
  } op_e;

  op_e op;
  assign op = op_e'(FunSel);

  logic [WIDTH-1:0] dr_q, dr_d;
  logic [CW-1:0]    count_q, count_d, len_q, len_d;
  logic             busy_q, busy_d, sext_q, sext_d;
  logic             done_q, done_d, err_q, err_d;
  logic             len_ok, last_byte;

  // Writes byte b into lane idx and refills every lane above it with the extension of b.
  function automatic logic [WIDTH-1:0] place(input logic [WIDTH-1:0] base,
                                             input int unsigned idx,
                                             input logic [7:0] b,
                                             input logic ext);
    logic [WIDTH-1:0] r;
    r = base;
    for (int unsigned k = 0; k < NBYTES; k++) begin
      if (k == idx)     r[8*k +: 8] = b;
      else if (k > idx) r[8*k +: 8] = {8{ext & b[7]}};
    end
    return r;
  endfunction

  assign len_ok    = (Len != '0) && (Len <= CW'(NBYTES));
  assign last_byte = ((count_q + CW'(1)) == len_q);

  always_comb begin
    dr_d    = dr_q;
    count_d = count_q;
    busy_d  = busy_q;
    len_d   = len_q;
    sext_d  = sext_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (E) begin
      unique case (op)
        OP_HOLD:  ;
        OP_SLOAD: dr_d = {{(WIDTH-8){I[7]}}, I};
        OP_ZLOAD: dr_d = {{(WIDTH-8){1'b0}}, I};
        OP_SHL:   dr_d = {dr_q[WIDTH-9:0], I};
        OP_SHR:   dr_d = {I, dr_q[WIDTH-1:8]};
        OP_START: begin
          if (len_ok) begin
            len_d   = Len;
            sext_d  = Sext;
            dr_d    = place('0, 0, I, Sext);
            count_d = CW'(1);
            busy_d  = (Len != CW'(1));
            done_d  = (Len == CW'(1));
          end else begin
            err_d = 1'b1;
          end
        end
        OP_APPEND: begin
          if (busy_q) begin
            dr_d    = place(dr_q, 32'(count_q), I, sext_q);
            count_d = count_q + CW'(1);
            busy_d  = !last_byte;
            done_d  = last_byte;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_CLEAR: begin
          dr_d    = '0;
          count_d = '0;
          busy_d  = 1'b0;
        end
        default: ;
      endcase
      // Plain loads/shifts issued mid-assembly abandon it without reporting completion.
      if (busy_q && (op inside {OP_SLOAD, OP_ZLOAD, OP_SHL, OP_SHR})) begin
        busy_d  = 1'b0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      dr_q    <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      len_q   <= '0;
      sext_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dr_q    <= dr_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      len_q   <= len_d;
      sext_q  <= sext_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign DROut = dr_q;
  assign Count = count_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Err   = err_q;

`ifdef DR_PARITY_EN
  logic [NBYTES-1:0] parity_q, parity_d;

  always_comb begin
    parity_d = '0;
    for (int unsigned k = 0; k < NBYTES; k++) parity_d[k] = ^dr_d[8*k +: 8];
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) parity_q <= '0;
    else        parity_q <= parity_d;
  end

  assign Parity = parity_q;
`endif

endmodule

// File: tb/tb_data_assembly_register.sv
// Scoreboard bench for data_assembly_register (WIDTH=32): a reference model pushes the
// expected post-edge state when stimulus is driven; it is popped and compared after the edge.
module tb_data_assembly_register;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 3;

  logic          Clock = 1'b0;
  logic          Reset;
  logic [7:0]    I;
  logic [2:0]    FunSel;
  logic          E;
  logic [CW-1:0] Len;
  logic          Sext;
  logic [W-1:0]  DROut;
  logic [CW-1:0] Count;
  logic          Busy, Done, Err;
`ifdef DR_PARITY_EN
  logic [3:0]    Parity;
`endif

  data_assembly_register #(.WIDTH(W), .CW(CW)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .FunSel(FunSel), .E(E), .Len(Len), .Sext(Sext),
    .DROut(DROut), .Count(Count), .Busy(Busy), .Done(Done), .Err(Err)
`ifdef DR_PARITY_EN
    , .Parity(Parity)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [W-1:0]  dr;
    logic [CW-1:0] cnt;
    logic          busy;
    logic          done;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]  m_dr;
  logic [CW-1:0] m_cnt, m_len;
  logic          m_busy, m_sext;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference assembly: keep lanes below n, put b in lane n, extend above by mask arithmetic.
  function automatic logic [W-1:0] asm_val(input logic [W-1:0] old, input int n,
                                           input logic [7:0] b, input logic s);
    logic [63:0] lo_mask, keep_mask;
    logic [W-1:0] v;
    keep_mask = (64'h1 << (8 * n)) - 64'h1;
    lo_mask   = (64'h1 << (8 * (n + 1))) - 64'h1;
    v = (old & keep_mask[W-1:0]) | (W'(b) << (8 * n));
    if (s && b[7]) v = v | ~lo_mask[W-1:0];
    return v;
  endfunction

  task automatic model_reset();
    m_dr = '0; m_cnt = '0; m_len = '0; m_busy = 1'b0; m_sext = 1'b0;
  endtask

  task automatic step(input logic e, input logic [2:0] fs, input logic [7:0] b,
                      input logic [CW-1:0] len, input logic s);
    exp_t x, got;
    logic dn, er;
    dn = 1'b0; er = 1'b0;
    if (e) begin
      if (m_busy && (fs inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd7})) begin
        m_busy = 1'b0; m_cnt = '0;
      end
      case (fs)
        3'd1: m_dr = b[7] ? (32'hFFFFFF00 | W'(b)) : W'(b);
        3'd2: m_dr = W'(b);
        3'd3: m_dr = (m_dr << 8) | W'(b);
        3'd4: m_dr = (m_dr >> 8) | (W'(b) << 24);
        3'd5: begin
          if (len >= 1 && len <= 4) begin
            m_len = len; m_sext = s;
            m_dr = asm_val('0, 0, b, s);
            m_cnt = 3'd1;
            m_busy = (len != 1);
            dn = (len == 1);
          end else er = 1'b1;
        end
        3'd6: begin
          if (m_busy) begin
            m_dr = asm_val(m_dr, int'(m_cnt), b, m_sext);
            m_cnt = m_cnt + 3'd1;
            if (m_cnt == m_len) begin m_busy = 1'b0; dn = 1'b1; end
          end else er = 1'b1;
        end
        3'd7: begin m_dr = '0; m_cnt = '0; m_busy = 1'b0; end
        default: ;
      endcase
    end
    x = '{dr: m_dr, cnt: m_cnt, busy: m_busy, done: dn, err: er};
    sb.push_back(x);
    E = e; FunSel = fs; I = b; Len = len; Sext = s;
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
    end else begin
      got = sb.pop_front();
      check("DROut", 64'(DROut), 64'(got.dr));
      check("Count", 64'(Count), 64'(got.cnt));
      check("Busy",  64'(Busy),  64'(got.busy));
      check("Done",  64'(Done),  64'(got.done));
      check("Err",   64'(Err),   64'(got.err));
`ifdef DR_PARITY_EN
      begin
        logic [3:0] p;
        for (int k = 0; k < 4; k++) p[k] = ^got.dr[8*k +: 8];
        check("Parity", 64'(Parity), 64'(p));
      end
`endif
    end
  endtask

  initial begin
    Reset = 1'b0; E = 1'b0; FunSel = '0; I = '0; Len = '0; Sext = 1'b0;
    model_reset();
    #12;
    check("rst_dr", 64'(DROut), 64'd0);
    check("rst_busy", 64'({Count, Busy, Done, Err}), 64'd0);
    Reset = 1'b1;
    @(posedge Clock); #1;

    // loads and shifts
    step(1, 3'd1, 8'h80, 0, 0); check("sload_const", 64'(DROut), 64'hFFFFFF80);
    step(1, 3'd3, 8'h12, 0, 0); check("shl_const",   64'(DROut), 64'hFFFF8012);
    step(1, 3'd4, 8'hAB, 0, 0); check("shr_const",   64'(DROut), 64'hABFFFF80);
    step(0, 3'd7, 8'h00, 0, 0);

    // counted assembly, sign then zero extension
    step(1, 3'd5, 8'h11, 3, 1);
    step(1, 3'd6, 8'h22, 0, 0);
    step(1, 3'd6, 8'h93, 0, 0);
    check("asm_sext", 64'(DROut), 64'hFF932211);
    check("asm_done", 64'({Done, Count}), 64'({1'b1, 3'd3}));
    step(1, 3'd0, 8'h00, 0, 0);
    step(1, 3'd5, 8'h11, 3, 0);
    step(1, 3'd6, 8'h22, 0, 0);
    step(1, 3'd6, 8'h93, 0, 0);
    check("asm_zext", 64'(DROut), 64'h00932211);

    // protocol errors
    step(1, 3'd6, 8'h55, 0, 0);
    step(1, 3'd5, 8'h55, 0, 0);
    step(1, 3'd5, 8'h55, 5, 0);
    check("err_dr_kept", 64'(DROut), 64'h00932211);

    // abort and restart
    step(1, 3'd5, 8'hF0, 4, 1);
    step(1, 3'd6, 8'h01, 0, 0);
    step(1, 3'd2, 8'h7F, 0, 0);
    check("abort_const", 64'({DROut, Count, Busy, Done}), 64'({32'h7F, 3'd0, 1'b0, 1'b0}));
    step(1, 3'd5, 8'hA1, 4, 0);
    step(1, 3'd6, 8'hA2, 0, 0);
    step(1, 3'd5, 8'hB1, 2, 1);
    step(1, 3'd6, 8'h82, 0, 0);
    check("restart_const", 64'(DROut), 64'hFFFF82B1);

    // Len=1, Done falls even while disabled; bad start while busy keeps assembly
    step(1, 3'd5, 8'h9C, 1, 1);
    step(0, 3'd7, 8'h00, 0, 0);
    step(1, 3'd5, 8'h01, 2, 0);
    step(1, 3'd5, 8'h01, 6, 0);
    step(1, 3'd6, 8'h02, 0, 0);

    // parity-oriented pattern
    step(1, 3'd2, 8'h01, 0, 0);
    step(1, 3'd3, 8'h03, 0, 0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      step(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 8'($urandom),
           3'($urandom_range(0, 6)), 1'($urandom));
    end

    // async reset mid-assembly at Count=2
    step(1, 3'd5, 8'h11, 4, 1);
    step(1, 3'd6, 8'h22, 0, 0);
    check("pre_rst_cnt", 64'(Count), 64'd2);
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst", 64'({DROut, Count, Busy, Done, Err}), 64'd0);
`ifdef DR_PARITY_EN
    check("async_rst_par", 64'(Parity), 64'd0);
`endif
    model_reset();
    @(posedge Clock); #1;
    check("rst_hold", 64'({DROut, Count, Busy, Done, Err}), 64'd0);
    Reset = 1'b1;
    step(1, 3'd5, 8'h44, 2, 0);
    step(1, 3'd6, 8'h55, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_assembly_register.md
# data_assembly_register

Parametrised successor to the 8-bit-fed data register. It takes bytes from the memory data bus and builds a WIDTH-bit operand for the ALU/register-file datapath. It keeps the single-shot load and shift modes, and adds a counted little-endian assembly mode with optional sign/zero extension. That mode raises Busy while assembling, pulses Done on completion, and flags protocol errors.

## Interface
- WIDTH, 32, register width in bits; multiple of 8, range 16..64; NBYTES = WIDTH/8.
- CW, $clog2(NBYTES+1), width of Len and Count.

- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- I  input  8  byte from memory bus.
- FunSel  input  3  operation select, sampled only when E=1.
- E  input  1  enable; E=0 means hold, except that Done/Err still self-clear.
- Len  input  CW  byte count for a Start operation, legal range 1..NBYTES.
- Sext  input  1  on Start: 1 sign-extends the assembled value, 0 zero-extends it.
- DROut  output  WIDTH  register contents.
- Count  output  CW  bytes written in the current assembly.
- Busy  output  1  assembly in progress.
- Done  output  1  one-cycle pulse after the final byte is written.
- Err  output  1  one-cycle pulse on an illegal request.

## Operation
All outputs reset to 0.

FunSel behaviour when E=1:
- 000 hold: DROut is unchanged.
- 001 sign-load: DROut = {(WIDTH-8){I[7]}, I}.
- 010 zero-load: DROut = {(WIDTH-8)'b0, I}.
- 011 shift-left: DROut = {DROut[WIDTH-9:0], I}.
- 100 shift-right: DROut = {I, DROut[WIDTH-1:8]}. I lands in the top byte; the old top byte moves down.
- 101 start:
  - If 1 <= Len <= NBYTES: latch Len and Sext; byte lane 0 = I; Count = 1; Busy = 1.
  - Upper lanes are filled as if this byte were the last one (sign or zero per Sext).
  - If Len = 1: Busy stays 0 and Done pulses.
  - If Len is out of range: DROut, Count and Busy are unchanged, and Err pulses.
- 110 append:
  - If Busy: byte lane Count = I; lanes above it are refilled with the sign of I when Sext, else with 0; Count increments.
  - If Count+1 equals the latched Len: Busy clears and Done pulses.
  - If not Busy: no state change, and Err pulses.
- 111 clear: DROut = 0, Count = 0, Busy = 0.

Rules that apply across modes:
- Any of 001..100 or 111 issued while Busy aborts the assembly: the operation executes, Busy = 0, Count = 0, and Done does not pulse.
- Start while Busy restarts the assembly from lane 0; Err does not pulse.
- Count holds its final value after Done until the next start, clear, or abort.
- E=0 freezes DROut, Count and Busy. Done and Err still fall the next cycle.
- Because the extension is refilled on every byte, DROut is always a valid extended value of the bytes received so far.

## Timing
- All outputs are registered. DROut, Count and Busy update on the rising edge where E=1.
- Done and Err are high for exactly the one cycle after the triggering edge.
- Assembly latency: Len enabled cycles from start to the final byte. Done is visible in the cycle after the final edge.
- No back-pressure: the block accepts one byte per enabled cycle, every cycle.
- Reset asserted mid-assembly immediately forces every output to 0. No completion is reported.

## Configuration
- DR_PARITY_EN defined:
  - Adds output Parity [NBYTES-1:0], reset value 0.
  - Parity[k] is the even parity (XOR) of DROut byte lane k.
  - It is registered on the same edge as DROut, computed from the next-state value, so it is always coherent with DROut.
- DR_PARITY_EN undefined: the Parity port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset low mid-assembly (WIDTH=32, Count=2) -> DROut=0, Count=0, Busy=0, Done=0, Err=0 immediately, without waiting for a Clock edge.
- FunSel=001 with I=0x80 -> DROut=0xFFFFFF80. Then FunSel=011 with I=0x12 -> DROut=0xFFFF8012. Then FunSel=100 with I=0xAB -> DROut=0xABFFFF80.
- Start with Len=3, Sext=1, then bytes 0x11, 0x22, 0x93 -> DROut=0xFF932211, Busy high for 2 cycles, Done pulses once with Count=3. The same sequence with Sext=0 -> DROut=0x00932211.
- Append while idle, and start with Len=0 and with Len=5 (WIDTH=32) -> Err pulses each time, and DROut is unchanged.
- Start with Len=4, one append, then FunSel=010 with I=0x7F -> DROut=0x0000007F, Busy=0, Count=0, no Done. Then start with Len=2 during a new assembly -> restart from lane 0, no Err.
- With DR_PARITY_EN, load 0x01 (zero-load) -> Parity=4'b0001. Then shift-left with I=0x03 -> Parity=4'b0010. Parity must match DROut every cycle.
